// File: rtl/uart_program_loader.sv
// Serial program loader: receives an 8N1 framed image (header, count, data, XOR checksum)
// and writes it into the 32-entry instruction memory, holding the CPU while loading.
module uart_program_loader #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HDR_BYTE     = 8'h55,
  parameter int         TIMEOUT_BITS = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       RX,
  output logic       Wr_en,
  output logic [4:0] Wr_addr,
  output logic [7:0] Wr_data,
  output logic       Cpu_hold,
  output logic       Load_done,
  output logic       Load_err,
  output logic       Rx_valid,
  output logic [7:0] Rx_byte
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);

  typedef enum logic [2:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP,
    U_WAIT_HIGH
  } uart_state_t;

  typedef enum logic [1:0] {
    L_HDR,
    L_CNT,
    L_DATA,
    L_CHK
  } load_state_t;

  // RX synchroniser, idles high
  logic rx_meta_reg;
  logic rx_s;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= RX;
      rx_s        <= rx_meta_reg;
    end
  end

  // UART receiver
  uart_state_t      u_state_reg, u_state_next;
  logic [CNT_W-1:0] u_cnt_reg, u_cnt_next;
  logic [2:0]       u_bit_reg, u_bit_next;
  logic [7:0]       u_shift_reg, u_shift_next;
  logic             rx_valid_reg, rx_valid_next;
  logic [7:0]       rx_byte_reg, rx_byte_next;
  logic             frame_err_reg, frame_err_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      u_state_reg   <= U_IDLE;
      u_cnt_reg     <= '0;
      u_bit_reg     <= '0;
      u_shift_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      rx_byte_reg   <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      u_state_reg   <= u_state_next;
      u_cnt_reg     <= u_cnt_next;
      u_bit_reg     <= u_bit_next;
      u_shift_reg   <= u_shift_next;
      rx_valid_reg  <= rx_valid_next;
      rx_byte_reg   <= rx_byte_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    u_state_next   = u_state_reg;
    u_cnt_next     = u_cnt_reg;
    u_bit_next     = u_bit_reg;
    u_shift_next   = u_shift_reg;
    rx_valid_next  = 1'b0;
    rx_byte_next   = rx_byte_reg;
    frame_err_next = 1'b0;
    case (u_state_reg)
      U_IDLE: begin
        if (!rx_s) begin
          u_state_next = U_START;
          u_cnt_next   = '0;
          u_bit_next   = '0;
        end
      end
      U_START: begin
        // Re-check at mid start bit so short glitches are dropped silently
        if (u_cnt_reg == HALF_LAST) begin
          u_cnt_next   = '0;
          u_state_next = rx_s ? U_IDLE : U_DATA;
        end else begin
          u_cnt_next = u_cnt_reg + 1'b1;
        end
      end
      U_DATA: begin
        if (u_cnt_reg == BIT_LAST) begin
          u_cnt_next   = '0;
          u_shift_next = {rx_s, u_shift_reg[7:1]};
          u_bit_next   = u_bit_reg + 1'b1;
          if (u_bit_reg == 3'd7) begin
            u_state_next = U_STOP;
          end
        end else begin
          u_cnt_next = u_cnt_reg + 1'b1;
        end
      end
      U_STOP: begin
        if (u_cnt_reg == BIT_LAST) begin
          u_cnt_next = '0;
          if (rx_s) begin
            rx_valid_next = 1'b1;
            rx_byte_next  = u_shift_reg;
            u_state_next  = U_IDLE;
          end else begin
            frame_err_next = 1'b1;
            u_state_next   = U_WAIT_HIGH;
          end
        end else begin
          u_cnt_next = u_cnt_reg + 1'b1;
        end
      end
      U_WAIT_HIGH: begin
        if (rx_s) begin
          u_state_next = U_IDLE;
        end
      end
      default: u_state_next = U_IDLE;
    endcase
  end

  // Frame loader
  load_state_t     l_state_reg, l_state_next;
  logic [5:0]      index_reg, index_next;
  logic [5:0]      count_reg, count_next;
  logic [7:0]      csum_reg, csum_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            wr_en_reg, wr_en_next;
  logic [4:0]      wr_addr_reg, wr_addr_next;
  logic [7:0]      wr_data_reg, wr_data_next;
  logic            hold_reg, hold_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      l_state_reg <= L_HDR;
      index_reg   <= '0;
      count_reg   <= '0;
      csum_reg    <= '0;
      to_cnt_reg  <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      hold_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      l_state_reg <= l_state_next;
      index_reg   <= index_next;
      count_reg   <= count_next;
      csum_reg    <= csum_next;
      to_cnt_reg  <= to_cnt_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      hold_reg    <= hold_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    l_state_next = l_state_reg;
    index_next   = index_reg;
    count_next   = count_reg;
    csum_next    = csum_reg;
    to_cnt_next  = to_cnt_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    hold_next    = hold_reg;
    done_next    = done_reg;
    err_next     = err_reg;
    case (l_state_reg)
      L_HDR: begin
        if (rx_valid_reg && rx_byte_reg == HDR_BYTE) begin
          l_state_next = L_CNT;
          hold_next    = 1'b1;
          done_next    = 1'b0;
          err_next     = 1'b0;
          index_next   = '0;
          csum_next    = '0;
        end
      end
      L_CNT: begin
        if (rx_valid_reg) begin
          if (rx_byte_reg != 8'd0 && rx_byte_reg <= 8'd32) begin
            count_next   = rx_byte_reg[5:0];
            l_state_next = L_DATA;
          end else begin
            err_next     = 1'b1;
            l_state_next = L_HDR;
          end
        end
      end
      L_DATA: begin
        if (rx_valid_reg) begin
          wr_en_next   = 1'b1;
          wr_addr_next = index_reg[4:0];
          wr_data_next = rx_byte_reg;
          index_next   = index_reg + 6'd1;
          csum_next    = csum_reg ^ rx_byte_reg;
          if (index_reg + 6'd1 == count_reg) begin
            l_state_next = L_CHK;
          end
        end
      end
      L_CHK: begin
        if (rx_valid_reg) begin
          if (rx_byte_reg == csum_reg) begin
            done_next = 1'b1;
            hold_next = 1'b0;
          end else begin
            err_next = 1'b1;
          end
          l_state_next = L_HDR;
        end
      end
      default: l_state_next = L_HDR;
    endcase

    // Abort inside a frame on a broken byte or an over-long silence
    if (l_state_reg != L_HDR && !rx_valid_reg &&
        (frame_err_reg || to_cnt_reg == TO_LAST)) begin
      err_next     = 1'b1;
      l_state_next = L_HDR;
    end

    // Silence is measured from the last accepted byte; a byte in flight is not silence
    if (l_state_next == L_HDR) begin
      to_cnt_next = '0;
    end else if (rx_valid_reg || u_state_reg != U_IDLE) begin
      to_cnt_next = TO_W'(1);
    end else begin
      to_cnt_next = to_cnt_reg + 1'b1;
    end
  end

  assign Wr_en     = wr_en_reg;
  assign Wr_addr   = wr_addr_reg;
  assign Wr_data   = wr_data_reg;
  assign Cpu_hold  = hold_reg;
  assign Load_done = done_reg;
  assign Load_err  = err_reg;
  assign Rx_valid  = rx_valid_reg;
  assign Rx_byte   = rx_byte_reg;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: table of framed images plus directed sequences for
// glitches, full-size loads, frame errors, inter-byte timeout and mid-frame reset.
module tb_uart_program_loader;

  localparam int CPB = 16;
  localparam int TOB = 4;
  localparam int GAP = 4;

  logic       Clk;
  logic       Reset;
  logic       RX;
  logic       Wr_en;
  logic [4:0] Wr_addr;
  logic [7:0] Wr_data;
  logic       Cpu_hold;
  logic       Load_done;
  logic       Load_err;
  logic       Rx_valid;
  logic [7:0] Rx_byte;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .HDR_BYTE    (8'h55),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .RX       (RX),
    .Wr_en    (Wr_en),
    .Wr_addr  (Wr_addr),
    .Wr_data  (Wr_data),
    .Cpu_hold (Cpu_hold),
    .Load_done(Load_done),
    .Load_err (Load_err),
    .Rx_valid (Rx_valid),
    .Rx_byte  (Rx_byte)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Output monitor: logs every write and Rx_valid, and when Load_err rises
  logic [4:0] wr_addr_log [0:255];
  logic [7:0] wr_data_log [0:255];
  int   wr_total = 0;
  int   rv_total = 0;
  int   last_rv_cyc = 0;
  int   err_rise_cyc = 0;
  logic err_prev = 1'b0;

  always @(negedge Clk) begin
    if (Wr_en && wr_total < 256) begin
      wr_addr_log[wr_total] = Wr_addr;
      wr_data_log[wr_total] = Wr_data;
      wr_total = wr_total + 1;
    end
    if (Rx_valid) begin
      rv_total    = rv_total + 1;
      last_rv_cyc = cyc;
    end
    if (Load_err && !err_prev) err_rise_cyc = cyc;
    err_prev = Load_err;
  end

  typedef struct {
    string       name;
    int          nbytes;
    logic [63:0] bytes;
    int          hdr_idx;
    int          nwr;
    logic [31:0] wd;
    logic        exp_done;
    logic        exp_err;
    logic        exp_hold;
  } vec_t;

  function automatic vec_t mk(input string n, input int nb, input logic [63:0] by,
                              input int hi, input int nw, input logic [31:0] wd,
                              input logic d, input logic e, input logic h);
    vec_t v;
    v.name = n; v.nbytes = nb; v.bytes = by; v.hdr_idx = hi; v.nwr = nw; v.wd = wd;
    v.exp_done = d; v.exp_err = e; v.exp_hold = h;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts and ends on a falling clock edge
  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int extra_low);
    RX = 1'b0;
    repeat (CPB) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge Clk);
    end
    RX = stop_val;
    repeat (CPB + extra_low) @(negedge Clk);
    RX = 1'b1;
    repeat (GAP) @(negedge Clk);
  endtask

  task automatic run_vec(input vec_t v);
    int base_wr = wr_total;
    for (int i = 0; i < v.nbytes; i++) begin
      send_byte(v.bytes[i*8 +: 8], 1'b1, 0);
      if (i == v.hdr_idx) begin
        chk({v.name, " hold_after_hdr"}, 32'(Cpu_hold), 32'd1);
        chk({v.name, " err_clr_after_hdr"}, 32'(Load_err), 32'd0);
        chk({v.name, " done_clr_after_hdr"}, 32'(Load_done), 32'd0);
      end
    end
    chk({v.name, " write_count"}, 32'(wr_total - base_wr), 32'(v.nwr));
    for (int k = 0; k < v.nwr; k++) begin
      chk($sformatf("%s wr_addr[%0d]", v.name, k), 32'(wr_addr_log[base_wr+k]), 32'(k));
      chk($sformatf("%s wr_data[%0d]", v.name, k), 32'(wr_data_log[base_wr+k]),
          32'(v.wd[k*8 +: 8]));
    end
    chk({v.name, " done"}, 32'(Load_done), 32'(v.exp_done));
    chk({v.name, " err"}, 32'(Load_err), 32'(v.exp_err));
    chk({v.name, " hold"}, 32'(Cpu_hold), 32'(v.exp_hold));
    chk({v.name, " rx_byte"}, 32'(Rx_byte), 32'(v.bytes[(v.nbytes-1)*8 +: 8]));
    $display("frame %s: %0d bytes, %0d writes, done=%0b err=%0b hold=%0b",
             v.name, v.nbytes, wr_total - base_wr, Load_done, Load_err, Cpu_hold);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t vecs [0:6];

  initial begin
    int base_wr;
    int base_rv;
    logic [7:0] csum;
    logic [7:0] d;

    vecs[0] = mk("good3",     6, 64'h0000_60E3_22A1_0355, 0, 3, 32'h00E3_22A1, 1'b1, 1'b0, 1'b0);
    vecs[1] = mk("badsum",    6, 64'h0000_61E3_22A1_0355, 0, 3, 32'h00E3_22A1, 1'b0, 1'b1, 1'b1);
    vecs[2] = mk("good1",     4, 64'h0000_0000_7E7E_0155, 0, 1, 32'h0000_007E, 1'b1, 1'b0, 1'b0);
    vecs[3] = mk("cnt00",     2, 64'h0000_0000_0000_0055, 0, 0, 32'h0,         1'b0, 1'b1, 1'b1);
    vecs[4] = mk("cnt21",     2, 64'h0000_0000_0000_2155, 0, 0, 32'h0,         1'b0, 1'b1, 1'b1);
    vecs[5] = mk("hdr_data",  5, 64'h0000_005A_0F55_0255, 0, 2, 32'h0000_0F55, 1'b1, 1'b0, 1'b0);
    vecs[6] = mk("junk_lead", 5, 64'h0000_00C3_C301_5512, 1, 1, 32'h0000_00C3, 1'b1, 1'b0, 1'b0);

    Reset = 1'b1;
    RX    = 1'b1;
    repeat (3) @(negedge Clk);
    chk("reset_outputs", 32'({Wr_en, Wr_addr, Wr_data, Cpu_hold, Load_done, Load_err,
                              Rx_valid, Rx_byte}), 32'd0);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    chk("post_reset_hold", 32'(Cpu_hold), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Short low glitch on idle line
    base_rv = rv_total;
    RX = 1'b0;
    repeat (4) @(negedge Clk);
    RX = 1'b1;
    repeat (40) @(negedge Clk);
    chk("glitch rx_valid", 32'(rv_total - base_rv), 32'd0);
    chk("glitch err", 32'(Load_err), 32'd0);
    chk("glitch done", 32'(Load_done), 32'd1);
    $display("glitch: rx_valid pulses=%0d err=%0b", rv_total - base_rv, Load_err);

    // Full 32-byte image
    base_wr = wr_total;
    csum = 8'h00;
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'h20, 1'b1, 0);
    for (int i = 0; i < 32; i++) begin
      d = 8'((i * 37 + 5) & 255);
      csum = csum ^ d;
      send_byte(d, 1'b1, 0);
    end
    send_byte(csum, 1'b1, 0);
    chk("n32 write_count", 32'(wr_total - base_wr), 32'd32);
    for (int i = 0; i < 32; i++) begin
      d = 8'((i * 37 + 5) & 255);
      chk($sformatf("n32 wr_addr[%0d]", i), 32'(wr_addr_log[base_wr+i]), 32'(i));
      chk($sformatf("n32 wr_data[%0d]", i), 32'(wr_data_log[base_wr+i]), 32'(d));
    end
    chk("n32 done", 32'(Load_done), 32'd1);
    chk("n32 err", 32'(Load_err), 32'd0);
    chk("n32 hold", 32'(Cpu_hold), 32'd0);
    $display("frame n32: %0d writes, done=%0b err=%0b", wr_total - base_wr, Load_done, Load_err);

    // Stop bit low mid-data, line held low (break) before recovering
    base_wr = wr_total;
    base_rv = rv_total;
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'h03, 1'b1, 0);
    send_byte(8'hA1, 1'b1, 0);
    send_byte(8'h22, 1'b0, 100);
    chk("brk rx_valid", 32'(rv_total - base_rv), 32'd3);
    chk("brk write_count", 32'(wr_total - base_wr), 32'd1);
    chk("brk err", 32'(Load_err), 32'd1);
    chk("brk done", 32'(Load_done), 32'd0);
    chk("brk hold", 32'(Cpu_hold), 32'd1);
    $display("break: rx_valid=%0d writes=%0d err=%0b", rv_total - base_rv,
             wr_total - base_wr, Load_err);
    run_vec(vecs[2]);

    // Silence after one data byte of a two-byte image
    base_wr = wr_total;
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    send_byte(8'h11, 1'b1, 0);
    chk("tmo err_before", 32'(Load_err), 32'd0);
    repeat (100) @(negedge Clk);
    chk("tmo err", 32'(Load_err), 32'd1);
    chk("tmo latency", 32'(err_rise_cyc - last_rv_cyc), 32'(TOB * CPB));
    chk("tmo write_count", 32'(wr_total - base_wr), 32'd1);
    chk("tmo done", 32'(Load_done), 32'd0);
    chk("tmo hold", 32'(Cpu_hold), 32'd1);
    $display("timeout: err after %0d cycles, writes=%0d", err_rise_cyc - last_rv_cyc,
             wr_total - base_wr);

    // Reset in the middle of the data phase
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'h03, 1'b1, 0);
    send_byte(8'hA1, 1'b1, 0);
    chk("mid hold_before_reset", 32'(Cpu_hold), 32'd1);
    #1;
    Reset = 1'b1;
    #1;
    chk("mid reset_outputs", 32'({Wr_en, Wr_addr, Wr_data, Cpu_hold, Load_done, Load_err,
                                  Rx_valid, Rx_byte}), 32'd0);
    $display("mid-frame reset: hold=%0b wr_data=%0h rx_byte=%0h", Cpu_hold, Wr_data, Rx_byte);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
